// File: rtl/array_wr_queue_pkg.sv
// Purpose: shared labels, default widths and the queued request type for array_wr_queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package array_wr_queue_pkg;

  // Default geometry of the labeled storage array and its write queue.
  localparam int DATA_W_DEF = 16;
  localparam int IDX_W_DEF  = 2;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 8;

  // Request label encodings carried on in_lbl.
  localparam logic LBL_L = 1'b0;
  localparam logic LBL_H = 1'b1;

  // One queued write request at default widths; index sits above data.
  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/array_wr_queue_mem.sv
// Purpose: DEPTH x W request storage, one synchronous write port, one async read port.
// Latency: write lands at the clock edge; read is combinational from raddr.
// Backpressure: none; the owner decides when we is asserted.
//
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write slot
//   wdata  - write word
//   raddr  - read slot
//   rdata  - word stored at raddr
module array_wr_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // Storage is not reset: the top masks the read port whenever the queue is empty.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/array_wr_queue.sv
// Purpose: in-order write-request queue feeding the L-labeled array; H requests are dropped and counted.
// Latency: 1 cycle from accepted L request to out_*; show-ahead head, 1 request/cycle sustained.
// Backpressure: in_ready drops only when DEPTH entries are held (no bypass on pop); out_ready pops the head.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake
//   in_lbl              - request label (0 = L, 1 = H)
//   in_idx, in_data     - request payload, only ever stored for L requests
//   out_valid/out_ready - head handshake toward the array write port
//   out_idx, out_data   - head entry, zero when the queue is empty
//   drop_cnt, drop_err  - saturating count / sticky flag of dropped H requests
//   clr_err             - clears drop_cnt and drop_err (wins over a same-cycle drop)
module array_wr_queue
  import array_wr_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_lbl,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              drop_err,
  input  logic              clr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = IDX_W + DATA_W;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             accept;
  logic             push;
  logic             drop;
  logic             pop;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] rdata;

  // Both handshake flags come straight from the registered occupancy.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);

  // The label alone decides between enqueue and drop; payload never steers control.
  assign accept = in_valid && in_ready;
  assign push   = accept && (in_lbl == LBL_L);
  assign drop   = accept && (in_lbl == LBL_H);
  assign pop    = out_valid && out_ready;

  // Payload is forced to zero unless this is an L enqueue, so H bits never reach the storage port.
  assign wdata = push ? {in_idx, in_data} : '0;

  array_wr_queue_mem #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Stale storage is hidden when empty so out_* read zero.
  assign out_idx  = out_valid ? rdata[ENT_W-1:DATA_W] : '0;
  assign out_data = out_valid ? rdata[DATA_W-1:0]     : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Drop accounting: clr_err has priority over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      drop_cnt <= '0;
      drop_err <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_array_wr_queue.sv
module tb_array_wr_queue;
  import array_wr_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 255;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_lbl;
  logic [1:0]  in_idx;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic [15:0] out_data;
  logic [7:0]  drop_cnt;
  logic        drop_err;
  logic        clr_err;

  int nvec  = 0;
  int nfail = 0;

  // Reference model: a plain queue plus drop counter and flag.
  wr_req_t m_q[$];
  int      m_cnt = 0;
  bit      m_err = 0;

  array_wr_queue #(
    .DATA_W (16),
    .IDX_W  (2),
    .DEPTH  (DEPTH),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lbl    (in_lbl),
    .in_idx    (in_idx),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt),
    .drop_err  (drop_err),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit      acc;
    bit      pp;
    wr_req_t e;
    if (reset) begin
      m_q.delete();
      m_cnt = 0;
      m_err = 0;
    end else begin
      acc = in_valid && (m_q.size() != DEPTH);
      pp  = (m_q.size() != 0) && out_ready;
      if (pp) void'(m_q.pop_front());
      if (acc && !in_lbl) begin
        e.idx  = in_idx;
        e.data = in_data;
        m_q.push_back(e);
      end
      if (clr_err) begin
        m_cnt = 0;
        m_err = 0;
      end else if (acc && in_lbl) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        m_err = 1;
      end
    end
  endtask

  // Every cycle: all outputs against the model.
  task automatic compare_all();
    bit vld;
    vld = (m_q.size() != 0);
    chk("in_ready",  32'(in_ready),  32'(m_q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(vld));
    chk("out_idx",   32'(out_idx),   vld ? 32'(m_q[0].idx)  : 32'd0);
    chk("out_data",  32'(out_data),  vld ? 32'(m_q[0].data) : 32'd0);
    chk("drop_cnt",  32'(drop_cnt),  32'(m_cnt));
    chk("drop_err",  32'(drop_err),  32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic lbl, input logic [1:0] idx,
                       input logic [15:0] d, input logic ordy, input logic clr);
    in_valid  = v;
    in_lbl    = lbl;
    in_idx    = idx;
    in_data   = d;
    out_ready = ordy;
    clr_err   = clr;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, 2'd0, 16'h0, ordy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b0);
    tick();
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    reset = 1'b0;

    // Single L push, visible one cycle later.
    drive(1'b1, LBL_L, 2'd1, 16'h00AA, 1'b0, 1'b0);
    tick();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_idx",   32'(out_idx),   32'd1);
    chk("first_data",  32'(out_data),  32'h00AA);
    idle(1'b1);
    tick();
    chk("first_drained", 32'(out_valid), 32'd0);

    // Fill to DEPTH, hold a 5th, H also stalls, no bypass when full.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, LBL_L, 2'(i), 16'h1000 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, LBL_L, 2'd3, 16'h5555, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, LBL_H, 2'd3, 16'h7777, 1'b0, 1'b0);
    tick();
    chk("full_h_stall", 32'(drop_cnt), 32'd0);
    drive(1'b1, LBL_L, 2'd3, 16'h5555, 1'b1, 1'b0);
    tick();
    chk("no_bypass_head", 32'(out_data), 32'h1001);
    chk("no_bypass_ready", 32'(in_ready), 32'd1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("drained", 32'(out_valid), 32'd0);

    // H request is dropped; following L shows no trace of it.
    drive(1'b1, LBL_H, 2'd3, 16'hBEEF, 1'b0, 1'b0);
    tick();
    chk("h_no_valid", 32'(out_valid), 32'd0);
    chk("h_drop_cnt", 32'(drop_cnt),  32'd1);
    chk("h_drop_err", 32'(drop_err),  32'd1);
    drive(1'b1, LBL_L, 2'd2, 16'h0123, 1'b0, 1'b0);
    tick();
    chk("after_h_idx",  32'(out_idx),  32'd2);
    chk("after_h_data", 32'(out_data), 32'h0123);
    idle(1'b1);
    tick();

    // Saturation, then clr_err beats a concurrent drop.
    drive(1'b0, LBL_L, 2'd0, 16'h0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, LBL_H, 2'(i), 16'(i * 7), 1'b0, 1'b0);
      tick();
    end
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    drive(1'b1, LBL_H, 2'd1, 16'hFFFF, 1'b0, 1'b1);
    tick();
    chk("clr_cnt", 32'(drop_cnt), 32'd0);
    chk("clr_err", 32'(drop_err), 32'd0);

    // Steady state at DEPTH-1 with simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, LBL_L, 2'(i), 16'h2000 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 3; i < 23; i++) begin
      drive(1'b1, LBL_L, 2'(i), 16'h2000 + 16'(i), 1'b1, 1'b0);
      tick();
      chk("steady_ready", 32'(in_ready), 32'd1);
      chk("steady_head",  32'(out_data), 32'h2000 + 32'(i - 2));
    end

    // Reset with 3 entries held and a nonzero drop count.
    drive(1'b1, LBL_H, 2'd0, 16'h0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    chk("mid_rst_cnt",   32'(drop_cnt),  32'd0);
    reset = 1'b0;
    idle(1'b1);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
